seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It owns one BCD-to-segment decoder and shares it across NDIG digits, cycling the digit enables with a programmable on/blank dwell. It accepts new display values through a load strobe, holds them in a shadow register and commits them only at frame boundaries, so a frame never mixes old and new digits. It sits between the application's BCD value register and the board's segment and anode pins.

## Interface
- NDIG, 4: number of digits (2..8).
- DWELL, 50000: cycles a digit is lit per scan slot (≥1).
- GAP, 500: all-off cycles between digit slots (≥1); suppresses ghosting.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset. **Asynchronous, active-high.**
- en  in  1  scan enable; 0 blanks the display.
- load  in  1  single-cycle strobe: capture data_in into the shadow register.
- data_in  in  4*NDIG  BCD digits; digit i = data_in[4i+3:4i], digit 0 rightmost.
- seg  out  7  segments, active-high, seg[0]=a … seg[6]=g.
- an  out  NDIG  digit enables, active-low.
- pending  out  1  shadow value waiting for commit.
- frame  out  1  one-cycle pulse on the last GAP cycle of digit NDIG-1.

## Operation
- Decode: 0–9 use standard patterns (0=7'h3F, 1=7'h06, 8=7'h7F, in {g..a} order); codes 10–15 are blank (seg=0).
- FSM states: GAP, ON. Cycle counter cnt, digit index idx (0..NDIG-1).
- ON: an[idx]=0, other an=1, seg=decode(active[idx]); after DWELL cycles → GAP, cnt=0.
- GAP: an all 1, seg=0; after GAP cycles → ON with idx+1, wrapping NDIG-1→0. On the wrap, frame=1 and the commit occurs.
- Commit: if pending=1, active←shadow and pending←0.
- load: shadow←data_in and pending←1 on the same edge, accepted in every state.
- load on the commit edge: active takes the old shadow; shadow takes the new data; pending stays 1.
- Repeated loads before a commit: the last value wins.
- en=0: next edge state=GAP, cnt=0, idx=0, an all 1, seg=0, and no frame pulse. A pending value commits on each edge while en=0.
- en rising: the scan starts at GAP with idx=0, i.e. digit NDIG-1's slot-end position; the first ON slot shows digit 0.

## Timing
- All outputs are registered and change together with the state.
- Reset values: state GAP, cnt=0, idx=0, an all 1, seg 0, pending 0, frame 0, active 0, shadow 0.
- After reset release with en=1: GAP for GAP cycles, then digit 0 is lit.
- Slot length: DWELL+GAP cycles. Frame length: NDIG*(DWELL+GAP) cycles.
- Load-to-visible latency: up to one frame plus GAP cycles; never mid-frame.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous); shadow and pending are cleared.
- Counter width: clog2(max(DWELL,GAP)+1). No overflow is possible.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. Digit i>0 is blanked (seg=0, an[i]=1 during its ON slot) when active[i] and all higher digits are 0. Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: every digit is displayed, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - the SEG_* pattern constants for 0–9 and SEG_BLANK;
  - the state enum (ST_GAP, ST_ON);
  - the BCD digit typedef (4 bits).
- Sub-module seg7_decode: purely combinational BCD→seg using the package constants; instantiated once.

## Test plan
Bench parameters: NDIG=4, DWELL=4, GAP=1 (frame = 20 cycles).
- Reset release, en=1, no load → 1 cycle all-off, then an=4'b1110 with seg=7'h3F for 4 cycles; the anode sequence 1110,1101,1011,0111 repeats every 20 cycles; frame pulses every 20 cycles.
- load data_in=16'h1234 mid-frame → pending=1. The current frame still shows 0000. From the next frame digit 0 shows 7'h66 ("4") and digit 3 shows 7'h06 ("1"); pending=0 after the frame pulse.
- load 16'h5678 on exactly the frame-pulse cycle while 16'h1234 is pending → the next frame shows 1234, pending stays 1, and the following frame shows 5678.
- data_in=16'h00AF → digits 0 and 1 produce seg=0 during their ON slots (codes F and A are blank). With SEG7_LZB_EN, digits 2 and 3 also keep an high.
- en dropped for 3 cycles mid-ON of digit 2 → an all 1 and seg 0 on the next edge. A pending value commits. After en returns: 1 GAP cycle, then digit 0 lit.
- rst asserted mid-ON for 1 cycle → an=4'b1111, seg=0, pending=0 with no clock edge. Operation restarts as after a fresh reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
// Segment patterns are in {g,f,e,d,c,b,a} order, active-high.
package seg7_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Scan FSM: all-off gap between digits, or one digit lit.
  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } st_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Larger of two non-negative integers; sizes the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to segment pattern. Codes 10..15 are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of NDIG common-anode digits.
// A shadow register takes new values on 'load'; they reach the displayed
// (active) register only at the frame wrap, so a frame never mixes values.
// Optional macro SEG7_LZB_EN: leading-zero blanking of digits 1..NDIG-1.
//
// Internally idx names the digit that is lit (ON) or about to be lit (GAP).
// GAP with idx=0 is therefore the end of digit NDIG-1's slot, which is the
// frame boundary: the frame pulse is raised there and the commit happens on
// the GAP->ON edge that leaves it.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GAP   = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] data_in,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame,
  output st_e               dbg_state
);

  localparam int CW = $clog2(max_int(DWELL, GAP) + 1);
  localparam int IW = $clog2(NDIG);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  st_e               st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              scanned_q, scanned_d;
  logic              commit;

  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;

  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_q, frame_d;

  bcd_t              digit_d;
  logic [6:0]        digit_seg;
  logic              blank_d;

  // Next scan state: dwell/gap counting, digit advance, and frame-wrap commit.
  // scanned_q marks that a digit has been lit since reset or enable, so the
  // start-up GAP never raises a frame pulse.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    scanned_d = scanned_q;
    commit    = 1'b0;
    if (!en) begin
      st_d      = ST_GAP;
      cnt_d     = '0;
      idx_d     = '0;
      scanned_d = 1'b0;
      commit    = 1'b1;
    end else begin
      case (st_q)
        ST_ON: begin
          scanned_d = 1'b1;
          if (cnt_q == DWELL_LAST) begin
            st_d  = ST_GAP;
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            st_d   = ST_ON;
            cnt_d  = '0;
            commit = (idx_q == '0);
          end
        end
        default: begin
          st_d  = ST_GAP;
          cnt_d = '0;
          idx_d = '0;
        end
      endcase
    end
  end

  // Shadow/active registers: commit uses the old shadow, then a load on the
  // same edge refills the shadow and keeps pending set.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

  assign digit_d = active_d[{idx_d, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd_i (digit_d),
    .seg_o (digit_seg)
  );

`ifdef SEG7_LZB_EN
  logic [4*NDIG-1:0] upper_d;
  // A digit above 0 is blanked when it and every higher digit are zero.
  always_comb begin
    upper_d = active_d >> {idx_d, 2'b00};
    blank_d = (idx_d != '0) && (upper_d == '0);
  end
`else
  // Every digit is shown, leading zeros included.
  always_comb begin
    blank_d = 1'b0;
  end
`endif

  // Registered pin values derived from the next state so they move with it.
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_BLANK;
    frame_d = en && scanned_q && (st_d == ST_GAP) && (idx_d == '0) &&
              (cnt_d == GAP_LAST);
    if ((st_d == ST_ON) && !blank_d) begin
      an_d  = ~(NDIG'(1) << idx_d);
      seg_d = digit_seg;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_GAP;
      cnt_q     <= '0;
      idx_q     <= '0;
      scanned_q <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      scanned_q <= scanned_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign pending   = pending_q;
  assign frame     = frame_q;
  assign dbg_state = st_q;

endmodule
